// File: rtl/echo_request_fifo.sv
// echo_request_fifo: first-word-fall-through request queue feeding the echo responder.
// Optional sticky protocol-error flag: define ECHO_FIFO_ERR_CHECK_EN.
module echo_request_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq__ENA,
    input  logic [WIDTH-1:0] enq_v,
    output logic             enq__RDY,
    input  logic             deq__ENA,
    output logic             deq__RDY,
    output logic [WIDTH-1:0] first,
    output logic             first__RDY,
`ifdef ECHO_FIFO_ERR_CHECK_EN
    output logic [AW:0]      count,
    output logic             err
`else
    output logic [AW:0]      count
`endif
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;
    logic             enq_ok;
    logic             deq_ok;

    assign enq__RDY   = (cnt != FULL_CNT);
    assign deq__RDY   = (cnt != '0);
    assign first__RDY = deq__RDY;
    assign enq_ok     = enq__ENA & enq__RDY;
    assign deq_ok     = deq__ENA & deq__RDY;
    assign count      = cnt;

    // Head is only exposed while an entry is held; stale storage reads as zero.
    always_comb begin
        first = '0;
        if (deq__RDY)
            first = mem[rd_ptr];
    end

    // Storage write; contents survive reset, only the pointers are cleared.
    always_ff @(posedge CLK) begin
        if (enq_ok)
            mem[wr_ptr] <= enq_v;
    end

    // Pointer and occupancy bookkeeping with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (deq_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({enq_ok, deq_ok})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef ECHO_FIFO_ERR_CHECK_EN
    // Sticky flag for a strobe raised while its method was not ready.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            err <= 1'b0;
        end else begin
            if (enq__ENA && !enq__RDY) begin
                err <= 1'b1;
                $display("echo_request_fifo: enq called while not ready");
            end
            if (deq__ENA && !deq__RDY) begin
                err <= 1'b1;
                $display("echo_request_fifo: deq called while not ready");
            end
        end
    end
`endif

endmodule
